// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard/forwarding unit
package hazard_pkg;

  // Default architectural register index width
  localparam int REG_AW_DEF = 5;

  // Storage width of a tracked destination index; must cover any REG_AW used
  localparam int REG_W_MAX = 16;

  // Select value meaning "take the operand from the register file"
  localparam int SEL_REGFILE = 0;

  // One in-flight producer record
  typedef struct packed {
    logic                 valid;
    logic [REG_W_MAX-1:0] wr_reg;
    logic                 is_load;
  } stage_rec_t;

  // Select width needed to encode register file (0) plus stages 1..num_stages
  function automatic int sel_width(input int num_stages);
    return $clog2(num_stages + 1);
  endfunction

endpackage

// File: rtl/hazard_src_match.sv
// rtl/hazard_src_match.sv - one source operand vs. all in-flight records, youngest match wins
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int NUM_STAGES       = 2,
  parameter int REG_AW           = REG_AW_DEF,
  parameter int LOAD_READY_STAGE = 2,
  parameter int SEL_W            = sel_width(NUM_STAGES)
) (
  input  logic [REG_AW-1:0] i_src_reg,
  input  logic              i_src_used,
  input  stage_rec_t        i_recs [1:NUM_STAGES],
  output logic [SEL_W-1:0]  o_sel,
  output logic              o_not_ready
);

  logic [REG_W_MAX-1:0] w_src_ext;
  logic                 w_src_live;

  assign w_src_ext  = REG_W_MAX'(i_src_reg);
  assign w_src_live = i_src_used & (i_src_reg != '0);

  // Scan oldest to youngest so the youngest matching stage overrides older ones
  always_comb begin
    o_sel       = SEL_W'(SEL_REGFILE);
    o_not_ready = 1'b0;
    for (int k = NUM_STAGES; k >= 1; k--) begin
      if (w_src_live && i_recs[k].valid && (i_recs[k].wr_reg == w_src_ext)) begin
        o_sel       = SEL_W'(k);
        o_not_ready = i_recs[k].is_load && (k < LOAD_READY_STAGE);
      end
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - ID-stage forwarding selects and load-use / HI-LO stall; HAZARD_STATS_EN adds stall/forward counters
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int NUM_SRC          = 4,
  parameter int NUM_STAGES       = 2,
  parameter int REG_AW           = REG_AW_DEF,
  parameter int LOAD_READY_STAGE = 2,
  parameter int MULDIV_LAT       = 4
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     adv,
  input  logic                                     flush,
  input  logic                                     id_valid,
  input  logic                                     id_wr_en,
  input  logic [REG_AW-1:0]                        id_wr_reg,
  input  logic                                     id_is_load,
  input  logic                                     id_is_muldiv,
  input  logic                                     id_uses_hilo,
  input  logic [NUM_SRC*REG_AW-1:0]                id_src_reg,
  input  logic [NUM_SRC-1:0]                       id_src_used,
  output logic [NUM_SRC*sel_width(NUM_STAGES)-1:0] fwd_sel,
  output logic                                     stall,
  output logic                                     muldiv_busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]                              stat_stall_cnt,
  output logic [31:0]                              stat_fwd_cnt
`endif
);

  localparam int SEL_W = sel_width(NUM_STAGES);
  localparam int CNT_W = $clog2(MULDIV_LAT + 1);

  stage_rec_t         r_stage [1:NUM_STAGES];
  logic [CNT_W-1:0]   r_md_cnt;

  logic [NUM_SRC-1:0] w_not_ready;
  logic               w_load_use;
  logic               w_hilo_hazard;
  logic               w_accept;
  logic               w_md_issue;
  stage_rec_t         w_new_rec;

  // One matcher per source operand
  generate
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      hazard_src_match #(
        .NUM_STAGES       (NUM_STAGES),
        .REG_AW           (REG_AW),
        .LOAD_READY_STAGE (LOAD_READY_STAGE),
        .SEL_W            (SEL_W)
      ) u_match (
        .i_src_reg   (id_src_reg[g*REG_AW +: REG_AW]),
        .i_src_used  (id_src_used[g]),
        .i_recs      (r_stage),
        .o_sel       (fwd_sel[g*SEL_W +: SEL_W]),
        .o_not_ready (w_not_ready[g])
      );
    end
  endgenerate

  assign w_load_use    = |w_not_ready;
  assign w_hilo_hazard = muldiv_busy & (id_is_muldiv | id_uses_hilo);
  assign stall         = id_valid & ~flush & (w_load_use | w_hilo_hazard);
  assign w_accept      = id_valid & id_wr_en & ~stall & ~flush;
  assign w_md_issue    = adv & id_valid & id_is_muldiv & ~stall & ~flush;
  assign muldiv_busy   = (r_md_cnt != '0);

  // Build the stage-1 record; writes to r0 or rejected issues become bubbles
  always_comb begin
    w_new_rec = '0;
    if (w_accept && (id_wr_reg != '0)) begin
      w_new_rec.valid   = 1'b1;
      w_new_rec.wr_reg  = REG_W_MAX'(id_wr_reg);
      w_new_rec.is_load = id_is_load;
    end
  end

  // Record shift pipeline: advance on adv, hold on freeze
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= NUM_STAGES; k++) r_stage[k] <= '0;
    end else if (adv) begin
      r_stage[1] <= w_new_rec;
      for (int k = 2; k <= NUM_STAGES; k++) r_stage[k] <= r_stage[k-1];
    end
  end

  // Mul/div busy counter: reloaded on issue, otherwise drains every cycle even when frozen
  always_ff @(posedge clk) begin
    if (rst) begin
      r_md_cnt <= '0;
    end else if (w_md_issue) begin
      r_md_cnt <= CNT_W'(MULDIV_LAT);
    end else if (r_md_cnt != '0) begin
      r_md_cnt <= r_md_cnt - CNT_W'(1);
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] r_stat_stall;
  logic [31:0] r_stat_fwd;
  logic        w_any_fwd;

  assign w_any_fwd      = |fwd_sel;
  assign stat_stall_cnt = r_stat_stall;
  assign stat_fwd_cnt   = r_stat_fwd;

  // Saturating event counters for stalled and forwarded advancing cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_stall <= '0;
      r_stat_fwd   <= '0;
    end else begin
      if (adv && stall && (r_stat_stall != '1)) r_stat_stall <= r_stat_stall + 32'd1;
      if (adv && id_valid && !stall && w_any_fwd && (r_stat_fwd != '1)) r_stat_fwd <= r_stat_fwd + 32'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - directed vector bench for hazard_forward_unit
module tb_hazard_forward_unit;

  logic        clk = 1'b0;
  logic        rst, adv, flush, id_valid, id_wr_en, id_is_load, id_is_muldiv, id_uses_hilo;
  logic [4:0]  id_wr_reg;
  logic [19:0] id_src_reg;
  logic [3:0]  id_src_used;
  logic [7:0]  fwd_sel;
  logic        stall, muldiv_busy;
`ifdef HAZARD_STATS_EN
  logic [31:0] stat_stall_cnt, stat_fwd_cnt;
`endif

  hazard_forward_unit dut (
    .clk          (clk),
    .rst          (rst),
    .adv          (adv),
    .flush        (flush),
    .id_valid     (id_valid),
    .id_wr_en     (id_wr_en),
    .id_wr_reg    (id_wr_reg),
    .id_is_load   (id_is_load),
    .id_is_muldiv (id_is_muldiv),
    .id_uses_hilo (id_uses_hilo),
    .id_src_reg   (id_src_reg),
    .id_src_used  (id_src_used),
    .fwd_sel      (fwd_sel),
    .stall        (stall),
    .muldiv_busy  (muldiv_busy)
`ifdef HAZARD_STATS_EN
    ,
    .stat_stall_cnt (stat_stall_cnt),
    .stat_fwd_cnt   (stat_fwd_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        adv, flush, valid, wr_en;
    logic [4:0]  wr_reg;
    logic        is_load, is_muldiv, uses_hilo;
    logic [19:0] src;
    logic [3:0]  used;
    logic [7:0]  exp_sel;
    logic        exp_stall, exp_busy;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic a, f, v, we, input logic [4:0] wr,
                              input logic ld, md, hl,
                              input logic [4:0] s0, s1, s2, s3, input logic [3:0] u,
                              input logic [1:0] e0, e1, e2, e3, input logic st, bz);
    vec_t t;
    t.adv = a; t.flush = f; t.valid = v; t.wr_en = we; t.wr_reg = wr;
    t.is_load = ld; t.is_muldiv = md; t.uses_hilo = hl;
    t.src = {s3, s2, s1, s0}; t.used = u;
    t.exp_sel = {e3, e2, e1, e0}; t.exp_stall = st; t.exp_busy = bz;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    adv = t.adv; flush = t.flush; id_valid = t.valid; id_wr_en = t.wr_en;
    id_wr_reg = t.wr_reg; id_is_load = t.is_load; id_is_muldiv = t.is_muldiv;
    id_uses_hilo = t.uses_hilo; id_src_reg = t.src; id_src_used = t.used;
  endtask

  task automatic check(input string name, input logic [7:0] es, input logic est, input logic eb);
    n_vec++;
    if (fwd_sel !== es || stall !== est || muldiv_busy !== eb) begin
      n_fail++;
      $display("FAIL %s: fwd_sel got %h want %h, stall got %b want %b, busy got %b want %b",
               name, fwd_sel, es, stall, est, muldiv_busy, eb);
    end
  endtask

  initial begin
    // ALU chain
    vecs.push_back(mk(1,0,1,1,5,0,0,0, 5,0,0,0,4'b0001, 0,0,0,0, 0,0));
    vecs.push_back(mk(1,0,1,0,0,0,0,0, 5,0,0,0,4'b0001, 1,0,0,0, 0,0));
    vecs.push_back(mk(1,0,1,0,0,0,0,0, 5,0,0,0,4'b0001, 2,0,0,0, 0,0));
    vecs.push_back(mk(1,0,1,0,0,0,0,0, 5,0,0,0,4'b0001, 0,0,0,0, 0,0));
    // Load-use: one stall, stalled writer not inserted, then ready at stage 2
    vecs.push_back(mk(1,0,1,1,8,1,0,0, 0,0,0,0,4'b0000, 0,0,0,0, 0,0));
    vecs.push_back(mk(1,0,1,1,9,0,0,0, 0,8,0,0,4'b0010, 0,1,0,0, 1,0));
    vecs.push_back(mk(1,0,1,1,9,0,0,0, 0,8,0,0,4'b0010, 0,2,0,0, 0,0));
    vecs.push_back(mk(1,0,1,0,0,0,0,0, 9,8,0,0,4'b0011, 1,0,0,0, 0,0));
    // Register 0 and unused sources
    vecs.push_back(mk(1,0,1,1,0,0,0,0, 0,0,0,0,4'b0000, 0,0,0,0, 0,0));
    vecs.push_back(mk(1,0,1,1,7,0,0,0, 0,0,9,0,4'b0101, 0,0,0,0, 0,0));
    vecs.push_back(mk(1,0,1,0,0,0,0,0, 0,0,7,7,4'b0100, 0,0,1,0, 0,0));
    // Priority and freeze
    vecs.push_back(mk(1,0,1,1,3,0,0,0, 0,0,0,0,4'b0000, 0,0,0,0, 0,0));
    vecs.push_back(mk(1,0,1,1,3,0,0,0, 3,0,0,0,4'b0001, 1,0,0,0, 0,0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0,0,1,0,0,0,0,0, 3,3,0,0,4'b0011, 1,1,0,0, 0,0));
    vecs.push_back(mk(1,0,1,0,0,0,0,0, 3,3,0,0,4'b0011, 1,1,0,0, 0,0));
    vecs.push_back(mk(1,0,1,0,0,0,0,0, 3,3,0,0,4'b0011, 2,2,0,0, 0,0));
    // Mul/div then HI/LO read: four stalled cycles, clear on the fifth
    vecs.push_back(mk(1,0,1,0,0,0,1,0, 0,0,0,0,4'b0000, 0,0,0,0, 0,0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1,0,1,0,0,0,0,1, 0,0,0,0,4'b0000, 0,0,0,0, 1,1));
    vecs.push_back(mk(1,0,1,0,0,0,0,1, 0,0,0,0,4'b0000, 0,0,0,0, 0,0));
    // Flush on stalled HI/LO read; counter keeps draining, also under freeze
    vecs.push_back(mk(1,0,1,0,0,0,1,0, 0,0,0,0,4'b0000, 0,0,0,0, 0,0));
    vecs.push_back(mk(1,1,1,0,0,0,0,1, 0,0,0,0,4'b0000, 0,0,0,0, 0,1));
    vecs.push_back(mk(1,0,1,0,0,0,0,1, 0,0,0,0,4'b0000, 0,0,0,0, 1,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,4'b0000, 0,0,0,0, 0,1));
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,0,4'b0000, 0,0,0,0, 0,1));
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,0,4'b0000, 0,0,0,0, 0,0));
    // Flushed load is never recorded
    vecs.push_back(mk(1,1,1,1,10,1,0,0, 0,0,0,0,4'b0000, 0,0,0,0, 0,0));
    vecs.push_back(mk(1,0,1,0,0,0,0,0, 10,0,0,0,4'b0001, 0,0,0,0, 0,0));

    rst = 1'b1;
    drive(mk(1,0,0,0,0,0,0,0, 0,0,0,0,4'b0000, 0,0,0,0, 0,0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 check("reset", 8'h00, 1'b0, 1'b0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1 check($sformatf("vec%0d", i), vecs[i].exp_sel, vecs[i].exp_stall, vecs[i].exp_busy);
    end

    // Reset in the middle of a load-use stall with mul/div busy
    @(negedge clk);
    drive(mk(1,0,1,1,13,0,1,0, 0,0,0,0,4'b0000, 0,0,0,0, 0,0));
    #1 check("rst_seq_md_issue", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    drive(mk(1,0,1,1,12,1,0,0, 0,0,0,0,4'b0000, 0,0,0,0, 0,0));
    #1 check("rst_seq_load", 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    drive(mk(1,0,1,0,0,0,0,0, 12,13,0,0,4'b0011, 0,0,0,0, 0,0));
    #1 check("rst_seq_stalled", 8'b0000_1001, 1'b1, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 check("rst_seq_after", 8'h00, 1'b0, 1'b0);
`ifdef HAZARD_STATS_EN
    n_vec++;
    if (stat_stall_cnt !== 32'd0 || stat_fwd_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL stats_after_reset: stall_cnt got %0d fwd_cnt got %0d want 0 and 0",
               stat_stall_cnt, stat_fwd_cnt);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Parametrised successor to the pipeline's combinational forwarding selector.
- Tracks in-flight destination registers in an internal shift pipeline of NUM_STAGES records.
- Per ID-stage source operand, produces forwarding mux selects; detects load-use and mul/div (HI/LO) hazards and raises stall.
- Sits beside the ID stage; its select outputs drive the operand muxes in the datapath.

Parameters:
- NUM_SRC, 4: number of source operands checked per cycle.
- NUM_STAGES, 2: number of tracked in-flight stages. Stage 1 = EX/MEM, stage k = k stages past ID.
- REG_AW, 5: register index width.
- LOAD_READY_STAGE, 2: first stage at which load data is forwardable; range 1..NUM_STAGES.
- MULDIV_LAT, 4: mul/div busy cycles after issue; must be ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- adv  in  1  pipeline advance; 0 = global freeze, so records hold
- flush  in  1  kill the current ID instruction
- id_valid  in  1  ID holds a valid instruction
- id_wr_en  in  1  ID instruction writes a register
- id_wr_reg  in  REG_AW  ID destination register
- id_is_load  in  1  ID instruction is a load
- id_is_muldiv  in  1  ID instruction is mul/div
- id_uses_hilo  in  1  ID instruction reads HI/LO
- id_src_reg  in  NUM_SRC*REG_AW  packed source register indices
- id_src_used  in  NUM_SRC  per-source used flag
- fwd_sel  out  NUM_SRC*SEL_W  per-source select; SEL_W = $clog2(NUM_STAGES+1)
- stall  out  1  hold ID/IF and insert a bubble
- muldiv_busy  out  1  mul/div counter nonzero

Behaviour:
- One clock (clk), synchronous active-high reset (rst); no other clock or reset.
- Record per stage: {valid, wr_reg, is_load}. A record with wr_reg=0 is never stored as valid.
- Reset: all records invalid, mul/div counter 0; hence fwd_sel=0, stall=0, muldiv_busy=0.
- Reset mid-operation discards every in-flight record and any busy count on the next edge.
- Accepted issue: accept = id_valid & id_wr_en & !stall & !flush.
- Edge with adv=1:
  - stage1 <= accept ? {1, id_wr_reg, id_is_load} : bubble;
  - stage k <= stage k-1 for k ≥ 2;
  - the oldest record is dropped.
- Edge with adv=0: all records hold.
- Ready rule: a record is ready at stage k if !is_load, or k ≥ LOAD_READY_STAGE.
- fwd_sel[i] is combinational from records and inputs, zero latency:
  - 0 if !id_src_used[i], or src=0, or no valid match;
  - otherwise the smallest k whose valid record has wr_reg == src; youngest match wins.
  - Meaning: 0 = register file, k = stage-k result.
- Load-use: if the youngest match for any used source is not ready, raise stall. fwd_sel still shows k.
- HI/LO hazard: raise stall if muldiv_busy & id_valid & (id_is_muldiv | id_uses_hilo).
- stall is gated by id_valid and forced 0 when flush=1.
- Mul/div counter:
  - on an edge with adv & id_valid & id_is_muldiv & !stall & !flush, load MULDIV_LAT;
  - else if nonzero, decrement every cycle regardless of adv.
  - muldiv_busy = (counter != 0).
  - flush never clears an already-running count.
- Simultaneous flush and stall: flush wins; the killed instruction's record is not inserted.
- Stall with adv=1 inserts exactly one bubble per stalled cycle.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined: adds outputs stat_stall_cnt[31:0] and stat_fwd_cnt[31:0], both reset to 0.
  - stat_stall_cnt increments on each cycle with stall=1 & adv=1.
  - stat_fwd_cnt increments on each adv cycle where id_valid=1, stall=0 and any fwd_sel ≠ 0.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package hazard_pkg holds:
  - REG_AW default;
  - stage record struct {valid, wr_reg, is_load};
  - a sel_width(NUM_STAGES) function;
  - the SEL_REGFILE=0 constant.
- Sub-module hazard_src_match: one source index vs. all records → {sel, not_ready}, priority youngest. Instantiated NUM_SRC times in a generate loop.
- Stall OR-reduction, record shift pipeline and mul/div counter live in the top module.

Test Plan:
- ALU chain: issue wr r5; next cycle src0=r5 → fwd_sel0=1, stall=0; one adv later, re-query r5 → sel=2; after a further adv → sel=0.
- Load-use: load r8, then src1=r8 → stall=1 for exactly one cycle with sel1=1; next cycle sel1=2, stall=0; one bubble visible in stage1.
- Register 0 and unused sources: write r0, then read r0 → sel=0, no stall; id_src_used=0 with a matching reg → sel=0, stall=0.
- Priority: r3 written twice consecutively (stages 1 and 2) → sel=1. adv=0 for 3 cycles → sel unchanged, records held.
- Mul/div, MULDIV_LAT=4: issue muldiv, then id_uses_hilo=1 → stall high 4 cycles, low on the 5th. flush on a stalled HI/LO read → stall=0, counter unaffected.
- Reset mid-load-use (stall=1) → next cycle stall=0, all fwd_sel=0, muldiv_busy=0. With HAZARD_STATS_EN, both counters read 0.
